// File: rtl/word_to_byte_unpacker_pkg.sv
// ---------------------------------------------------------------------------
// word_to_byte_unpacker_pkg
//
// Purpose:
//   Shared definitions for the shift/pack/unpack family of blocks. It holds
//   the two-state handshake FSM encoding and the default byte width, so every
//   block in the family agrees on both.
//
// Contents:
//   BYTE_W_DEFAULT    - default width of one byte lane in bits
//   NUM_BYTES_MIN/MAX - supported range for the number of bytes in a word
//   unpackState_t     - IDLE (nothing held) / SEND (word held, bytes pending)
// ---------------------------------------------------------------------------
package word_to_byte_unpacker_pkg;

  localparam int BYTE_W_DEFAULT = 8;

  localparam int NUM_BYTES_MIN = 2;
  localparam int NUM_BYTES_MAX = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } unpackState_t;

endpackage : word_to_byte_unpacker_pkg

// File: rtl/word_to_byte_unpacker.sv
// ---------------------------------------------------------------------------
// word_to_byte_unpacker
//
// Purpose:
//   Takes one parallel word of NUM_BYTES bytes and emits it as a stream of
//   single bytes, most-significant byte first. Both sides use valid/ready
//   handshakes. The next word can be accepted in the same cycle as the
//   final byte of the current word, so a steady stream runs at one byte per
//   clock with no bubbles.
//
// Parameters:
//   BYTE_W    - width of one output byte in bits (default from package)
//   NUM_BYTES - bytes per input word, 2..8
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous flush; drops any held word
//   in_data   in   parallel word, BYTE_W*NUM_BYTES bits
//   in_valid  in   in_data is valid
//   in_ready  out  a word is accepted this cycle
//   out_data  out  current byte (MSB byte of the holding register)
//   out_valid out  out_data is valid
//   out_ready in   downstream takes the byte
//   out_last  out  out_data is the final byte of its word
//   busy      out  a word is held (same as out_valid)
// ---------------------------------------------------------------------------
module word_to_byte_unpacker
  import word_to_byte_unpacker_pkg::*;
#(
  parameter int BYTE_W    = BYTE_W_DEFAULT,
  parameter int NUM_BYTES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [BYTE_W*NUM_BYTES-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BYTE_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy
);

  localparam int WORD_W  = BYTE_W * NUM_BYTES;
  localparam int COUNT_W = $clog2(NUM_BYTES);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(NUM_BYTES - 1);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  // Reject illegal word sizes at elaboration time rather than building a
  // block whose count or shift slices would be meaningless.
  if ((NUM_BYTES < NUM_BYTES_MIN) || (NUM_BYTES > NUM_BYTES_MAX)) begin : g_bad_num_bytes
    $error("word_to_byte_unpacker: NUM_BYTES out of range");
  end
  if (BYTE_W < 1) begin : g_bad_byte_w
    $error("word_to_byte_unpacker: BYTE_W must be positive");
  end

  unpackState_t       r_state;
  logic [WORD_W-1:0]  r_hold;
  logic [COUNT_W-1:0] r_count;

  logic w_sending;
  logic w_lastByte;
  logic w_inFire;
  logic w_outFire;
  logic [WORD_W-1:0] w_holdShifted;

  // The outputs come straight from the state, holding register and count,
  // so they stay stable under backpressure without any extra storage.
  // The holding register is zeroed whenever the block goes idle, so out_data
  // reads zero when nothing is held.
  assign w_sending  = (r_state == ST_SEND);
  assign w_lastByte = w_sending && (r_count == LAST_COUNT);

  assign out_valid = w_sending;
  assign busy      = w_sending;
  assign out_last  = w_lastByte;
  assign out_data  = r_hold[WORD_W-1 -: BYTE_W];

  // A new word can be taken when idle, or when the final byte of the held
  // word is leaving this very cycle. clr suppresses acceptance so a flush
  // never overlaps a load.
  always_comb begin
    in_ready = 1'b0;
    if (!clr) begin
      if (!w_sending) begin
        in_ready = 1'b1;
      end else if (w_lastByte && out_ready) begin
        in_ready = 1'b1;
      end
    end
  end

  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = out_valid && out_ready;

  // Moving to the next byte means shifting the word left one byte lane with
  // zero fill, so the next byte always sits at the top of the register.
  assign w_holdShifted = {r_hold[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};

  // Main FSM. Reset and clr both drop everything and return to IDLE; clr is
  // checked first so it beats any handshake happening in the same cycle.
  // In SEND, a final-byte handshake either reloads from the input (staying
  // in SEND for bubble-free streaming) or returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_inFire) begin
            r_state <= ST_SEND;
            r_hold  <= in_data;
            r_count <= '0;
          end
        end
        ST_SEND: begin
          if (w_outFire) begin
            if (w_lastByte) begin
              if (w_inFire) begin
                r_state <= ST_SEND;
                r_hold  <= in_data;
                r_count <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
                r_count <= '0;
              end
            end else begin
              r_hold  <= w_holdShifted;
              r_count <= r_count + COUNT_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hold  <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule : word_to_byte_unpacker

// File: tb/tb_word_to_byte_unpacker.sv
// ---------------------------------------------------------------------------
// tb_word_to_byte_unpacker
//
// Directed bench for word_to_byte_unpacker. One instance uses the default
// two-byte word and another uses a four-byte word. Each scenario task drives
// its own stimulus and compares the outputs against hand-computed bytes.
// ---------------------------------------------------------------------------
module tb_word_to_byte_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;

  logic [15:0] inData = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        outLast;
  logic        busy;

  logic [31:0] inData4 = '0;
  logic        inValid4 = 1'b0;
  logic        inReady4;
  logic [7:0]  outData4;
  logic        outValid4;
  logic        outReady4 = 1'b0;
  logic        outLast4;
  logic        busy4;

  int vectors = 0;
  int miscompares = 0;

  word_to_byte_unpacker #(.BYTE_W(8), .NUM_BYTES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_last  (outLast),
    .busy      (busy)
  );

  word_to_byte_unpacker #(.BYTE_W(8), .NUM_BYTES(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (inData4),
    .in_valid  (inValid4),
    .in_ready  (inReady4),
    .out_data  (outData4),
    .out_valid (outValid4),
    .out_ready (outReady4),
    .out_last  (outLast4),
    .busy      (busy4)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid got %b want 0", outValid);
    end
    vectors++;
    if (outLast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_last got %b want 0", outLast);
    end
    vectors++;
    if (outData !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_out_data got %h want 00", outData);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got %b want 1", inReady);
    end
    vectors++;
    if (outValid4 !== 1'b0 || inReady4 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset4 got valid=%b ready=%b want valid=0 ready=1", outValid4, inReady4);
    end
  endtask

  task automatic test_single_word();
    inData   = 16'hA55A;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_pre got ready=%b valid=%b want ready=1 valid=0", inReady, outValid);
    end
    tick();
    inValid = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b1 || outData !== 8'hA5 || outLast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_byte0 got v=%b d=%h l=%b want v=1 d=a5 l=0", outValid, outData, outLast);
    end
    vectors++;
    if (inReady !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_byte0_ctl got ready=%b busy=%b want ready=0 busy=1", inReady, busy);
    end
    tick();
    vectors++;
    if (outValid !== 1'b1 || outData !== 8'h5A || outLast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_byte1 got v=%b d=%h l=%b want v=1 d=5a l=1", outValid, outData, outLast);
    end
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_last_ready got %b want 1", inReady);
    end
    tick();
    vectors++;
    if (outValid !== 1'b0 || busy !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_idle got v=%b busy=%b ready=%b want 0 0 1", outValid, busy, inReady);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expByte [4];
    logic       expLast [4];
    expByte = '{8'h12, 8'h34, 8'h56, 8'h78};
    expLast = '{1'b0, 1'b1, 1'b0, 1'b1};
    inData   = 16'h1234;
    inValid  = 1'b1;
    outReady = 1'b1;
    tick();
    inData = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outData !== expByte[i] || outLast !== expLast[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_byte%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, outValid, outData, outLast, expByte[i], expLast[i]);
      end
      if (i == 2) inValid = 1'b0;
      tick();
    end
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle got v=%b want 0", outValid);
    end
  endtask

  task automatic test_backpressure();
    inData   = 16'hBEEF;
    inValid  = 1'b1;
    outReady = 1'b0;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outData !== 8'hBE || outLast !== 1'b0 || inReady !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d got v=%b d=%h l=%b ready=%b want v=1 d=be l=0 ready=0",
                 i, outValid, outData, outLast, inReady);
      end
      tick();
    end
    outReady = 1'b1;
    tick();
    vectors++;
    if (outValid !== 1'b1 || outData !== 8'hEF || outLast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_release got v=%b d=%h l=%b want v=1 d=ef l=1", outValid, outData, outLast);
    end
    tick();
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_idle got v=%b want 0", outValid);
    end
  endtask

  task automatic test_reset_mid_word();
    inData   = 16'hCAFE;
    inValid  = 1'b1;
    outReady = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    vectors++;
    if (outData !== 8'hCA || outValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_first got v=%b d=%h want v=1 d=ca", outValid, outData);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (outValid !== 1'b0 || outData !== 8'h00 || outLast !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async got v=%b d=%h l=%b busy=%b want 0 00 0 0", outValid, outData, outLast, busy);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rstmid_no_fe%0d got v=%b d=%h ready=%b want v=0 ready=1", i, outValid, outData, inReady);
      end
    end
    inData  = 16'h0102;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b1 || outData !== 8'h01 || outLast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_next0 got v=%b d=%h l=%b want v=1 d=01 l=0", outValid, outData, outLast);
    end
    tick();
    vectors++;
    if (outValid !== 1'b1 || outData !== 8'h02 || outLast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_next1 got v=%b d=%h l=%b want v=1 d=02 l=1", outValid, outData, outLast);
    end
    tick();
  endtask

  task automatic test_clear();
    inData   = 16'h00FF;
    inValid  = 1'b1;
    outReady = 1'b1;
    tick();
    inValid = 1'b0;
    #1;
    vectors++;
    if (outData !== 8'h00 || outValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_byte0 got v=%b d=%h want v=1 d=00", outValid, outData);
    end
    tick();
    clr     = 1'b1;
    inValid = 1'b1;
    inData  = 16'h1234;
    #1;
    vectors++;
    if (outData !== 8'hFF || outLast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_byte1 got d=%h l=%b want d=ff l=1", outData, outLast);
    end
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clr_in_ready got %b want 0", inReady);
    end
    tick();
    clr     = 1'b0;
    inValid = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b0 || busy !== 1'b0 || outData !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL clr_idle got v=%b busy=%b d=%h want 0 0 00", outValid, busy, outData);
    end
    tick();
    vectors++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_stay_idle got v=%b ready=%b want 0 1", outValid, inReady);
    end
  endtask

  task automatic test_four_bytes();
    logic [7:0] expByte [4];
    expByte = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    inData4   = 32'hDEADBEEF;
    inValid4  = 1'b1;
    outReady4 = 1'b1;
    tick();
    inValid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (outValid4 !== 1'b1 || outData4 !== expByte[i] || outLast4 !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL four_byte%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, outValid4, outData4, outLast4, expByte[i], (i == 3));
      end
      tick();
    end
    vectors++;
    if (outValid4 !== 1'b0 || busy4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL four_idle got v=%b busy=%b want 0 0", outValid4, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_clear();
    test_four_bytes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_word_to_byte_unpacker

// File: doc/word_to_byte_unpacker.md
WORD_TO_BYTE_UNPACKER -- requirements
Module: word_to_byte_unpacker

Interface
REQ-001 SHALL provide parameter BYTE_W, default 8, width of one output byte in bits.
REQ-002 SHALL provide parameter NUM_BYTES, default 2, bytes per input word; legal range 2..8.
REQ-003 SHALL provide port clk, input, 1, rising-edge clock.
REQ-004 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port clr, input, 1, synchronous flush; discards the held word.
REQ-006 SHALL provide port in_data, input, BYTE_W*NUM_BYTES, parallel word to unpack.
REQ-007 SHALL provide port in_valid, input, 1, in_data is valid.
REQ-008 SHALL provide port in_ready, output, 1, unpacker accepts a word this cycle.
REQ-009 SHALL provide port out_data, output, BYTE_W, current byte.
REQ-010 SHALL provide port out_valid, output, 1, out_data is valid.
REQ-011 SHALL provide port out_ready, input, 1, downstream accepts the byte.
REQ-012 SHALL provide port out_last, output, 1, out_data is the final byte of its word.
REQ-013 SHALL provide port busy, output, 1, a word is held (equal to out_valid).

Function
REQ-014 SHALL transfer on the input side only when in_valid and in_ready are both high at a rising clk edge, and on the output side only when out_valid and out_ready are both high.
REQ-015 SHALL use two states: IDLE (no word held) and SEND (word held, bytes pending).
REQ-016 SHALL, in IDLE, drive in_ready=1 and out_valid=0; an input handshake loads in_data into the holding register, clears byte count to 0 and moves to SEND.
REQ-017 SHALL, in SEND, drive out_valid=1 and out_data equal to the most-significant BYTE_W bits of the holding register (big-endian: MSB byte first).
REQ-018 SHALL, on each output handshake that is not the last byte, shift the holding register left by BYTE_W with zero fill and increment the byte count.
REQ-019 SHALL drive out_last=1 exactly when byte count equals NUM_BYTES-1 and out_valid=1.
REQ-020 SHALL drive in_ready=1 in SEND only while out_last=1 and out_ready=1, so a new word loads in the same cycle as the final byte handshake.
REQ-021 SHALL, on a final-byte handshake with a simultaneous input handshake, load the new word, reset the count to 0 and remain in SEND; sustained throughput is one byte per cycle, no bubble.
REQ-022 SHALL, on a final-byte handshake without an input handshake, return to IDLE.
REQ-023 SHALL hold out_data, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL have latency of one cycle from input handshake to first out_valid.
REQ-025 SHALL give clr priority over all handshakes: the held word is discarded, the count is set to 0, the state goes to IDLE, and in_ready=0 during the clr cycle.
REQ-026 SHALL implement the byte count with width $clog2(NUM_BYTES) and never exceed NUM_BYTES-1.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, the holding register to all zeros and the count to 0.
REQ-028 SHALL reset outputs as follows: out_valid=0, out_last=0, out_data=0, busy=0; in_ready=1 after rst deasserts.
REQ-029 SHALL drop any partially sent word when rst asserts mid-operation; no byte of it is emitted after reset.

Structure
REQ-030 SHALL take the state encoding (IDLE, SEND) and the BYTE_W default from the shared package used by the team's shift and pack blocks.
REQ-031 SHALL be a single module with no sub-modules; the holding register, counter and FSM are local.

Verification
REQ-032 Scenario: single word 16'hA55A, out_ready=1 -> out_data 8'hA5 (out_last=0), then 8'h5A (out_last=1), then IDLE.
REQ-033 Scenario: back-to-back words 16'h1234 and 16'h5678, in_valid=1 and out_ready=1 continuously -> bytes 12,34,56,78 on four consecutive cycles, out_valid never drops.
REQ-034 Scenario: word 16'hBEEF, out_ready=0 for 3 cycles -> out_data holds 8'hBE with out_valid=1 and in_ready=0, then EF after out_ready rises.
REQ-035 Scenario: rst pulse after byte 8'hCA of 16'hCAFE -> outputs go to reset values, 8'hFE is never emitted, and the next word 16'h0102 yields 01,02.
REQ-036 Scenario: clr asserted together with in_valid during the final byte of 16'h00FF -> in_ready=0, word is dropped, state is IDLE the next cycle.
REQ-037 Scenario: NUM_BYTES=4, word 32'hDEADBEEF -> DE,AD,BE,EF with out_last only on EF.
